btn_sync_debounce: RTL and testbench
====================================

Name: btn_sync_debounce

Overview:
- Multi-channel successor to the single-button falling-edge synchroniser.
- Each channel takes an asynchronous push-button input and runs it through:
  - a parametrised synchroniser chain,
  - a debounce filter (input must hold for N cycles),
  - rise and fall edge detection.
- Outputs per channel: one-cycle active-high rise and fall pulses, plus the filtered level.
- Sits between board buttons and control FSMs (e.g. ALU operand/op-select capture).

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 4, consecutive mismatching cycles required to accept a new level (>=1).
- IDLE_LEVEL, 1, released-button level; reset value of the sync chain and of level.
- HOLD_CYCLES, 16, auto-repeat initial hold delay (used only with the optional feature).
- REPEAT_CYCLES, 8, auto-repeat period (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- button  input  CHANNELS  raw asynchronous button inputs.
- level  output  CHANNELS  debounced, registered button level.
- fall_pulse  output  CHANNELS  one-cycle high on an accepted high-to-low transition (press).
- rise_pulse  output  CHANNELS  one-cycle high on an accepted low-to-high transition (release).
- any_press  output  1  OR of fall_pulse, same cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All sync flops and level := IDLE_LEVEL.
  - Debounce counters := 0.
  - fall_pulse, rise_pulse, any_press := 0.
- Reset asserted mid-count discards in-progress debounce and pulses immediately.
- Synchroniser: per channel, a shift chain of SYNC_STAGES flops; the last stage is "s".
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - s == level: counter := 0; no pulse.
  - s != level and counter < DEBOUNCE_CYCLES-1: counter += 1.
  - s != level and counter == DEBOUNCE_CYCLES-1: counter := 0; level := s; pulse asserted.
    - The pulse is fall_pulse if s == 0, rise_pulse if s == 1.
- Any return of s to level before acceptance clears the counter, so glitches shorter than DEBOUNCE_CYCLES produce nothing. Bounce restarts the count.
- Latency: let E0 be the first clock edge that samples the new button value.
  - level and the pulse update at edge E0 + SYNC_STAGES - 1 + DEBOUNCE_CYCLES.
  - Pulses are registered, exactly one cycle wide, and never high in consecutive cycles from debounce alone.
- Channels are fully independent. Simultaneous events on several channels produce their pulses in the same cycle.
- After reset release, a button held at non-idle level is treated as a transition: a pulse is issued after the normal latency.
- A channel never has fall_pulse and rise_pulse high together.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: per-channel hold counter, active while level == ~IDLE_LEVEL (pressed).
  - Counting starts at the cycle after the accepted press pulse.
  - After HOLD_CYCLES pressed cycles, fall_pulse re-fires for one cycle.
  - It then re-fires every REPEAT_CYCLES cycles while still pressed.
  - Release (level returning to IDLE_LEVEL) or reset clears the hold counter immediately; no repeat in the release cycle.
  - any_press includes repeat pulses.
- Undefined: no hold counters are synthesised. Exactly one fall_pulse per accepted press.

Test Plan (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1):
- Reset asserted, button=4'hF, reset released → level=4'hF; fall_pulse=rise_pulse=0; any_press=0 for 20 cycles.
- button[0] 1→0 held, sampled at E0 → fall_pulse=4'b0001 and any_press=1 for exactly one cycle at E0+5; level=4'hE from E0+5.
- button[1] low for 3 cycles then high → no pulses; level[1] stays 1 throughout.
- button[2] sequence low 2, high 1, low held → single fall_pulse[2], 5 edges after the final low is sampled; no rise_pulse.
- Same edge: button[0] 0→1 and button[3] 1→0 → rise_pulse=4'b0001 and fall_pulse=4'b1000 in the same cycle.
- Reset pulsed low while ch0 counter=2 → pulses 0 and level=4'hF immediately. With button[0] still low after release → fall_pulse[0] 5 edges later.
- With BTN_AUTOREPEAT_EN and HOLD_CYCLES=16, REPEAT_CYCLES=8, button[0] held low → fall_pulse[0] at acceptance, then 16 cycles later, then every 8 cycles until release.

Source files
------------

// File: rtl/btn_sync_debounce.sv
// -----------------------------------------------------------------------------
// btn_sync_debounce
//
// Multi-channel push-button conditioner. Each channel runs its raw button
// input through a synchroniser chain and a debounce filter, then produces
// one-cycle press (fall) and release (rise) pulses plus the filtered level.
//
// Optional feature: define BTN_AUTOREPEAT_EN to add per-channel auto-repeat.
// While a channel stays pressed, fall_pulse re-fires HOLD_CYCLES cycles after
// the press pulse and then every REPEAT_CYCLES cycles until release.
// Without the macro no hold counters exist and each press gives one pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous assert, active-low reset
//   button     in   [CHANNELS] raw asynchronous button inputs
//   level      out  [CHANNELS] debounced, registered button level
//   fall_pulse out  [CHANNELS] one-cycle pulse on accepted high-to-low (press)
//   rise_pulse out  [CHANNELS] one-cycle pulse on accepted low-to-high (release)
//   any_press  out  OR of fall_pulse, same cycle
// -----------------------------------------------------------------------------
module btn_sync_debounce #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic                any_press
);

  localparam int                  CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] IDLE_VEC = {CHANNELS{IDLE_LEVEL}};

  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("btn_sync_debounce: illegal parameter value");
  end

  // Synchroniser chain: stage 0 samples the raw pins, the last stage is the
  // metastability-resolved value fed to the debounce filter.
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] rise_d;

  assign s = sync_q[SYNC_STAGES-1];

`ifdef BTN_AUTOREPEAT_EN
  localparam int            HW        = $clog2(((HOLD_CYCLES > REPEAT_CYCLES) ?
                                                HOLD_CYCLES : REPEAT_CYCLES) + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  // hold_q counts pressed cycles since the last press or repeat pulse;
  // rep_q selects the repeat period once the initial hold has expired.
  logic [HW-1:0]       hold_q [CHANNELS];
  logic [HW-1:0]       hold_d [CHANNELS];
  logic [CHANNELS-1:0] rep_q;
  logic [CHANNELS-1:0] rep_d;
`endif

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    level_d = level;
    fall_d  = '0;
    rise_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = '0;
      // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any
      // return to the current level falls through with the counter cleared.
      if (s[c] != level[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          level_d[c] = s[c];
          fall_d[c]  = ~s[c];
          rise_d[c]  = s[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    for (int c = 0; c < CHANNELS; c++) begin
      hold_d[c] = '0;
      rep_d[c]  = 1'b0;
      // Count only while pressed and not releasing this cycle, so the release
      // cycle never carries a repeat and the counter clears at once.
      if (level[c] != IDLE_LEVEL && level_d[c] == level[c]) begin
        if (hold_q[c] == (rep_q[c] ? REP_LAST : HOLD_LAST)) begin
          fall_d[c] = 1'b1;
          rep_d[c]  = 1'b1;
        end else begin
          hold_d[c] = hold_q[c] + 1'b1;
          rep_d[c]  = rep_q[c];
        end
      end
    end
`endif
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes the sync chain a real shift chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-channel counter arrays are ordinary flops, not memory,
      // so they are reset explicitly to drop any in-progress count.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_VEC;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      level      <= IDLE_VEC;
      fall_pulse <= '0;
      rise_pulse <= '0;
      any_press  <= 1'b0;
    end else begin
      sync_q[0] <= button;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
      level      <= level_d;
      fall_pulse <= fall_d;
      rise_pulse <= rise_d;
      any_press  <= |fall_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) hold_q[c] <= '0;
      rep_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) hold_q[c] <= hold_d[c];
      rep_q <= rep_d;
    end
  end
`endif

endmodule

// File: tb/tb_btn_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_sync_debounce
//
// Scoreboard bench for btn_sync_debounce (4 channels, 2 sync stages,
// 4-cycle debounce, idle level 1). The stimulus process keeps a reference
// model that works from the per-edge history of sampled button values: a
// channel accepts a new level when the synchronised input (the button value
// sampled SYNC edges earlier) has differed from the level on each of the last
// DEBOUNCE edges since the previous acceptance. Expected outputs are queued
// per edge; a monitor pops and compares on the following falling edge.
// Define BTN_AUTOREPEAT_EN for both DUT and bench to model auto-repeat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_sync_debounce;

  localparam int       NCH      = 4;
  localparam int       SYNC     = 2;
  localparam int       DEBOUNCE = 4;
  localparam bit       IDLE     = 1'b1;
  localparam int       HOLD     = 16;
  localparam int       REP      = 8;
  localparam logic [3:0] IDLE_VEC = 4'hF;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] button;
  logic [NCH-1:0] level;
  logic [NCH-1:0] fall_pulse;
  logic [NCH-1:0] rise_pulse;
  logic           any_press;

  btn_sync_debounce #(
    .CHANNELS       (NCH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEBOUNCE),
    .IDLE_LEVEL     (IDLE),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .level     (level),
    .fall_pulse(fall_pulse),
    .rise_pulse(rise_pulse),
    .any_press (any_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] fall;
    logic [3:0] rise;
    logic       any;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] hist[$];
  logic [3:0] m_level;
  int         last_acc [NCH];
`ifdef BTN_AUTOREPEAT_EN
  int         press_edge [NCH];
`endif
  int         total = 0;
  int         bad   = 0;
  int         mon_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Synchronised value seen by the filter at edge e (sync chain resets idle).
  function automatic logic [3:0] s_at(input int e);
    if (e >= SYNC) return hist[e-SYNC];
    return IDLE_VEC;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_level = IDLE_VEC;
    for (int c = 0; c < NCH; c++) begin
      last_acc[c] = -1;
`ifdef BTN_AUTOREPEAT_EN
      press_edge[c] = 0;
`endif
    end
  endtask

  // Evaluate one clock edge: record the sampled button and queue the outputs
  // the DUT must show after this edge.
  task automatic model_edge();
    exp_t       x;
    int         n;
    bit         ok;
    logic [3:0] sv;
    hist.push_back(button);
    n = hist.size() - 1;
    x = '0;
    for (int c = 0; c < NCH; c++) begin
      ok = 1'b1;
      for (int k = 0; k < DEBOUNCE; k++) begin
        sv = s_at(n - k);
        if ((n - k) <= last_acc[c] || sv[c] == m_level[c]) ok = 1'b0;
      end
      if (ok) begin
        m_level[c]  = ~m_level[c];
        last_acc[c] = n;
        if (m_level[c] == 1'b0) begin
          x.fall[c] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          press_edge[c] = n;
`endif
        end else begin
          x.rise[c] = 1'b1;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (m_level[c] != IDLE) begin
        int d;
        d = n - press_edge[c];
        if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) x.fall[c] = 1'b1;
      end
`endif
    end
    x.level = m_level;
    x.any   = |x.fall;
    exp_q.push_back(x);
  endtask

  // Drive v, let the next rising edge sample it, then model that edge.
  task automatic cycle(input logic [3:0] v, input int count = 1);
    for (int i = 0; i < count; i++) begin
      button = v;
      @(posedge clk);
      #1;
      model_edge();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_level", 32'(level), 32'(IDLE_VEC));
    check("rst_fall", 32'(fall_pulse), 32'h0);
    check("rst_rise", 32'(rise_pulse), 32'h0);
    check("rst_any", 32'(any_press), 32'h0);
    model_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: one expected record per edge, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cyc++;
        check($sformatf("level@%0d", mon_cyc), 32'(level), 32'(e.level));
        check($sformatf("fall@%0d", mon_cyc), 32'(fall_pulse), 32'(e.fall));
        check($sformatf("rise@%0d", mon_cyc), 32'(rise_pulse), 32'(e.rise));
        check($sformatf("any@%0d", mon_cyc), 32'(any_press), 32'(e.any));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         run [NCH];
    logic [3:0] cur;
    reset  = 1'b1;
    button = IDLE_VEC;
    model_reset();
    #1;
    do_reset();

    // Idle after reset: no activity for 20 cycles.
    cycle(4'hF, 20);
    // Channel 0 press, held.
    cycle(4'hE, 10);
    // Channel 1 glitch of 3 cycles: filtered out.
    cycle(4'hC, 3);
    cycle(4'hE, 10);
    // Channel 2 bounce: low 2, high 1, then low held.
    cycle(4'hA, 2);
    cycle(4'hE, 1);
    cycle(4'hA, 10);
    // Same edge: channel 0 released, channel 3 pressed.
    cycle(4'h3, 10);
    // Channel 0 pressed again, reset while its counter is at 2.
    cycle(4'h2, 4);
    do_reset();
    cycle(4'h2, 10);
    // Release all, then long hold on channel 0 (auto-repeat when enabled).
    cycle(4'hF, 10);
    cycle(4'hE, 60);
    cycle(4'hF, 10);

    // Randomised bouncy inputs: short runs act as glitches, long runs settle.
    cur = button;
    for (int c = 0; c < NCH; c++) run[c] = 0;
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (run[c] == 0) begin
          cur[c] = ~cur[c];
          run[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 40));
        end
        run[c]--;
      end
      cycle(cur);
      if (i % 300 == 299) do_reset();
    end
    cycle(4'hF, 10);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
